cmd_sequencer: RTL

CMD_SEQUENCER -- requirements
Module: cmd_sequencer

---
 rtl/cmd_sequencer_pkg.sv | 57 +++++
 rtl/sample_timer.sv | 39 +++
 rtl/cmd_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cmd_sequencer_pkg.sv
// Shared definitions for the command sequencer:
// opcodes, command field positions and FSM state encodings.
package cmd_sequencer_pkg;

  localparam int CMD_W  = 80;
  localparam int OPC_HI = 79;
  localparam int OPC_LO = 72;
  localparam int PIN_HI = 67;
  localparam int PIN_LO = 64;
  localparam int T_HI   = 63;
  localparam int T_LO   = 32;
  localparam int A_HI   = 31;
  localparam int A_LO   = 16;
  localparam int B_HI   = 15;
  localparam int B_LO   = 0;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_SET_OUT = 8'h01;
  localparam logic [7:0] OP_SET_IN  = 8'h02;
  localparam logic [7:0] OP_SAMPLE  = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_WAIT   = 3'd3,
    S_EXEC   = 3'd4,
    S_SAMPLE = 3'd5
  } state_e;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [3:0]  pin;
    logic [31:0] start;
    logic [15:0] a;
    logic [15:0] b;
  } cmd_t;

  // Build a command word in the FIFO layout; bits [71:68] stay zero.
  function automatic logic [CMD_W-1:0] cmd_pack(
    input logic [7:0]  op,
    input logic [3:0]  pin,
    input logic [31:0] start,
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [CMD_W-1:0] w;
    w = '0;
    w[OPC_HI:OPC_LO] = op;
    w[PIN_HI:PIN_LO] = pin;
    w[T_HI:T_LO]     = start;
    w[A_HI:A_LO]     = a;
    w[B_HI:B_LO]     = b;
    return w;
  endfunction

endpackage

// File: rtl/sample_timer.sv
// Sample count / period timer: loaded with count A and period B,
// emits a tick every B+1 enabled cycles (first one immediately), done on the last.
module sample_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [15:0] count_i,
  input  logic [15:0] period_i,
  output logic        tick_o,
  output logic        done_o
);

  logic [15:0] rem_q;
  logic [15:0] per_q;
  logic [15:0] b_q;

  assign tick_o = en_i && (rem_q != '0) && (per_q == '0);
  assign done_o = tick_o && (rem_q == 16'd1);

  // Remaining-sample and inter-sample countdown registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      per_q <= '0;
      b_q   <= '0;
    end else if (load_i) begin
      rem_q <= count_i;
      per_q <= '0;
      b_q   <= period_i;
    end else if (tick_o) begin
      rem_q <= rem_q - 16'd1;
      per_q <= b_q;
    end else if (en_i && per_q != '0) begin
      per_q <= per_q - 16'd1;
    end
  end

endmodule

// File: rtl/cmd_sequencer.sv
// Timed pin command sequencer: pops 80-bit commands, waits for their
// start time, then drives pins or streams pin samples into a FIFO.
module cmd_sequencer
  import cmd_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CMD_W-1:0]  cmd_fifo_data_out,
  output logic              cmd_fifo_rd_en,
  input  logic              cmd_fifo_empty,
  output logic [15:0]       sample_fifo_data_in,
  output logic              sample_fifo_wr_en,
  input  logic              sample_fifo_full,
  input  logic [31:0]       global_clock,
  input  logic [15:0]       pin_in,
  output logic [15:0]       pin_out,
  output logic [15:0]       pin_oe,
  output logic              busy,
  output logic              err_bad_opcode,
  output logic              err_sample_overflow
);

  state_e      state_q;
  cmd_t        cmd_q;
  logic        rd_q;
  logic        wr_q;
  logic [15:0] data_q;
  logic [15:0] pin_out_q;
  logic [15:0] pin_oe_q;
  logic        err_op_q;
  logic        err_ov_q;
  logic [10:0] idx_q;
  logic        tick;
  logic        done;
  logic        unused_rsvd;

  assign unused_rsvd = ^cmd_fifo_data_out[71:68];

  sample_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (state_q == S_EXEC && cmd_q.opcode == OP_SAMPLE),
    .en_i     (state_q == S_SAMPLE),
    .count_i  (cmd_q.a),
    .period_i (cmd_q.b),
    .tick_o   (tick),
    .done_o   (done)
  );

  assign cmd_fifo_rd_en      = rd_q & ~rst;
  assign sample_fifo_wr_en   = wr_q & ~rst;
  assign sample_fifo_data_in = data_q;
  assign pin_out             = pin_out_q;
  assign pin_oe              = pin_oe_q;
  assign busy                = (state_q != S_IDLE);
  assign err_bad_opcode      = err_op_q;
  assign err_sample_overflow = err_ov_q;

  // Command FSM with registered strobes, pin state and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      data_q    <= '0;
      pin_out_q <= '0;
      pin_oe_q  <= '0;
      err_op_q  <= 1'b0;
      err_ov_q  <= 1'b0;
      idx_q     <= '0;
    end else begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (!cmd_fifo_empty) begin
            state_q <= S_FETCH;
            rd_q    <= 1'b1;
          end
        end
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          cmd_q.opcode <= cmd_fifo_data_out[OPC_HI:OPC_LO];
          cmd_q.pin    <= cmd_fifo_data_out[PIN_HI:PIN_LO];
          cmd_q.start  <= cmd_fifo_data_out[T_HI:T_LO];
          cmd_q.a      <= cmd_fifo_data_out[A_HI:A_LO];
          cmd_q.b      <= cmd_fifo_data_out[B_HI:B_LO];
          state_q      <= S_WAIT;
        end
        S_WAIT: begin
          if (global_clock >= cmd_q.start) state_q <= S_EXEC;
        end
        S_EXEC: begin
          state_q <= S_IDLE;
          idx_q   <= '0;
          case (cmd_q.opcode)
            OP_NOP: ;
            OP_SET_OUT: begin
              pin_out_q[cmd_q.pin] <= cmd_q.a[0];
              pin_oe_q[cmd_q.pin]  <= 1'b1;
            end
            OP_SET_IN: pin_oe_q[cmd_q.pin] <= 1'b0;
            OP_SAMPLE: begin
              if (cmd_q.a != '0) state_q <= S_SAMPLE;
            end
            default: err_op_q <= 1'b1;
          endcase
        end
        S_SAMPLE: begin
          if (tick) begin
            if (sample_fifo_full) begin
              err_ov_q <= 1'b1;
            end else begin
              wr_q   <= 1'b1;
              data_q <= {pin_in[cmd_q.pin], idx_q, cmd_q.pin};
            end
            idx_q <= idx_q + 11'd1;
            if (done) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
